// File: rtl/axis_gen_pkg.sv
// Shared definitions for the AXI4-Stream packet generator: FSM encoding and LFSR constants.
// The LFSR step lives here so the generator can look one beat ahead of the LFSR register.
package axis_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } gen_state_t;

    localparam logic [31:0] LFSR_POLY         = 32'h80200003;
    localparam logic [31:0] LFSR_DEFAULT_SEED = 32'h1;

    // Right-shifting Galois step for x^32+x^22+x^2+x+1.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

    // An all-zero state would lock the LFSR, so seed 0 maps to the default seed.
    function automatic logic [31:0] lfsr_seed_fix(input logic [31:0] s);
        return (s == 32'h0) ? LFSR_DEFAULT_SEED : s;
    endfunction

endpackage

// File: rtl/axis_lfsr32.sv
// 32-bit Galois LFSR: loads a (zero-safe) seed, steps once per advance.
// Latency: state updates on the edge following load/advance; load wins over advance.
module axis_lfsr32
    import axis_gen_pkg::*;
(
    input  logic        clk,
    input  logic        aresetn,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        advance,
    output logic [31:0] state
);

    logic [31:0] r_state;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= LFSR_DEFAULT_SEED;
        end else if (load) begin
            r_state <= lfsr_seed_fix(seed);
        end else if (advance) begin
            r_state <= lfsr_step(r_state);
        end
    end

    assign state = r_state;

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI4-Stream packet generator: start -> num_pkts packets of pkt_len_bytes, counter or LFSR payload.
// Latency: first beat valid one cycle after start; all outputs registered; tvalid/beat held under backpressure.
module axis_pkt_gen
    import axis_gen_pkg::*;
#(
    parameter int TDATA_WIDTH = 64,
    parameter int TDATA_BYTES = 8,
    parameter int LEN_WIDTH   = 16,
    parameter int GAP_WIDTH   = 8
) (
    input  logic                   m_axis_aclk,
    input  logic                   m_axis_aresetn,
    input  logic                   start,
    input  logic [LEN_WIDTH-1:0]   pkt_len_bytes,
    input  logic [7:0]             num_pkts,
    input  logic [GAP_WIDTH-1:0]   gap_cycles,
    input  logic                   pattern_sel,
    input  logic [31:0]            seed,
    output logic                   busy,
    output logic                   done,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [TDATA_BYTES-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [31:0]            beat_count,
    output logic [15:0]            pkt_count
);

    localparam int                     SHIFT    = $clog2(TDATA_BYTES);
    localparam logic [TDATA_BYTES-1:0] KEEP_ALL = '1;

    gen_state_t             r_state, w_next;
    logic [LEN_WIDTH-1:0]   r_len, r_beat_idx;
    logic [7:0]             r_pkts_left;
    logic [GAP_WIDTH-1:0]   r_gap, r_gap_cnt;
    logic                   r_pat, r_empty, r_busy, r_done;
    logic [TDATA_WIDTH-1:0] r_tdata;
    logic [TDATA_BYTES-1:0] r_tkeep;
    logic                   r_tlast, r_tvalid;
    logic [31:0]            r_beat_cnt;
    logic [15:0]            r_pkt_cnt;

    logic                   w_accept, w_start, w_zero, w_empty_go, w_pkt_end;
    logic                   w_load, w_first, w_pat, w_nb_last;
    logic [LEN_WIDTH-1:0]   w_len, w_nbeats, w_nb_idx;
    logic [SHIFT-1:0]       w_rem;
    logic [31:0]            w_lfsr, w_nb_lfsr;
    logic [TDATA_BYTES-1:0] w_nb_keep;
    logic [TDATA_WIDTH-1:0] w_nb_dat;

    assign w_accept   = r_tvalid & m_axis_tready;
    assign w_start    = (r_state == IDLE) & start;
    assign w_zero     = (pkt_len_bytes == '0) | (num_pkts == 8'd0);
    assign w_empty_go = w_start & w_zero;
    assign w_pkt_end  = (r_state == SEND) & w_accept & r_tlast;

    axis_lfsr32 u_lfsr (
        .clk     (m_axis_aclk),
        .aresetn (m_axis_aresetn),
        .load    (w_start),
        .seed    (seed),
        .advance (w_accept),
        .state   (w_lfsr)
    );

    // An empty run lingers one extra cycle in DONE so busy is seen before the done pulse.
    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_first = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_zero) begin
                        w_next = DONE;
                    end else begin
                        w_next  = SEND;
                        w_load  = 1'b1;
                        w_first = 1'b1;
                    end
                end
            end
            SEND: begin
                if (w_accept) begin
                    if (!r_tlast) begin
                        w_load = 1'b1;
                    end else if (r_pkts_left == 8'd1) begin
                        w_next = DONE;
                    end else if (r_gap == '0) begin
                        w_load  = 1'b1;
                        w_first = 1'b1;
                    end else begin
                        w_next = GAP;
                    end
                end
            end
            GAP: begin
                if (r_gap_cnt == GAP_WIDTH'(1)) begin
                    w_next  = SEND;
                    w_load  = 1'b1;
                    w_first = 1'b1;
                end
            end
            DONE: begin
                if (!r_empty) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Next beat to present: config comes straight from the ports on the start cycle.
    assign w_len     = (r_state == IDLE) ? pkt_len_bytes : r_len;
    assign w_pat     = (r_state == IDLE) ? pattern_sel : r_pat;
    assign w_rem     = w_len[SHIFT-1:0];
    assign w_nbeats  = (w_len >> SHIFT) + LEN_WIDTH'(w_rem != '0);
    assign w_nb_idx  = w_first ? '0 : r_beat_idx + LEN_WIDTH'(1);
    assign w_nb_last = (w_nb_idx == w_nbeats - LEN_WIDTH'(1));
    assign w_nb_keep = (w_nb_last && (w_rem != '0)) ? (KEEP_ALL >> (TDATA_BYTES - int'(w_rem))) : KEEP_ALL;

    // In GAP the LFSR has already stepped past the last accepted beat.
    assign w_nb_lfsr = (r_state == IDLE) ? lfsr_seed_fix(seed) :
                       (r_state == SEND) ? lfsr_step(w_lfsr) : w_lfsr;

    always_comb begin
        w_nb_dat = '0;
        for (int j = 0; j < TDATA_BYTES; j++) begin
            if (w_nb_keep[j]) begin
                w_nb_dat[j*8 +: 8] = w_pat ? w_nb_lfsr[(j%4)*8 +: 8]
                                           : 8'(32'(w_nb_idx) * 32'(TDATA_BYTES) + 32'(j));
            end
        end
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_beat_idx  <= '0;
            r_pkts_left <= '0;
            r_gap       <= '0;
            r_gap_cnt   <= '0;
            r_pat       <= 1'b0;
            r_empty     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_tdata     <= '0;
            r_tkeep     <= '0;
            r_tlast     <= 1'b0;
            r_tvalid    <= 1'b0;
            r_beat_cnt  <= '0;
            r_pkt_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_empty <= w_empty_go;
            r_done  <= (w_next == DONE) & ~w_empty_go;
            r_busy  <= (w_next == SEND) | (w_next == GAP) | w_empty_go;

            if (w_start) begin
                r_len       <= pkt_len_bytes;
                r_pkts_left <= num_pkts;
                r_gap       <= gap_cycles;
                r_pat       <= pattern_sel;
                r_beat_cnt  <= '0;
                r_pkt_cnt   <= '0;
            end else begin
                if (w_accept) r_beat_cnt <= r_beat_cnt + 32'd1;
                if (w_pkt_end) begin
                    r_pkt_cnt   <= r_pkt_cnt + 16'd1;
                    r_pkts_left <= r_pkts_left - 8'd1;
                end
            end

            if (w_pkt_end) begin
                r_gap_cnt <= r_gap;
            end else if (r_state == GAP) begin
                r_gap_cnt <= r_gap_cnt - GAP_WIDTH'(1);
            end

            if (w_load) begin
                r_tvalid   <= 1'b1;
                r_tdata    <= w_nb_dat;
                r_tkeep    <= w_nb_keep;
                r_tlast    <= w_nb_last;
                r_beat_idx <= w_nb_idx;
            end else if (w_accept) begin
                r_tvalid <= 1'b0;
                r_tdata  <= '0;
                r_tkeep  <= '0;
                r_tlast  <= 1'b0;
            end
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tkeep  = r_tkeep;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tvalid = r_tvalid;
    assign beat_count    = r_beat_cnt;
    assign pkt_count     = r_pkt_cnt;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Bench for axis_pkt_gen: randomized runs scored against a byte-level packet model.
module tb_axis_pkt_gen;

    localparam int TDB = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] pkt_len_bytes = '0;
    logic [7:0]  num_pkts = '0;
    logic [7:0]  gap_cycles = '0;
    logic        pattern_sel = 1'b0;
    logic [31:0] seed = '0;
    logic        tready = 1'b0;
    logic        busy, done, m_axis_tlast, m_axis_tvalid;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic [31:0] beat_count;
    logic [15:0] pkt_count;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_dat[$];
    logic [7:0]  exp_keep[$];
    logic        exp_last[$];
    logic [63:0] acc_dat[$];
    logic [7:0]  acc_keep[$];
    logic        acc_last[$];

    axis_pkt_gen dut (
        .m_axis_aclk    (clk),
        .m_axis_aresetn (rst_n),
        .start          (start),
        .pkt_len_bytes  (pkt_len_bytes),
        .num_pkts       (num_pkts),
        .gap_cycles     (gap_cycles),
        .pattern_sel    (pattern_sel),
        .seed           (seed),
        .busy           (busy),
        .done           (done),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (tready),
        .beat_count     (beat_count),
        .pkt_count      (pkt_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
    endfunction

    // Reference: every packet is a sequence of byte lanes filled from the pattern.
    task automatic build_model(input int len, input int num, input bit pat, input logic [31:0] sd);
        logic [31:0] s;
        logic [63:0] d;
        logic [7:0]  k;
        int nb, nbytes;
        exp_dat.delete(); exp_keep.delete(); exp_last.delete();
        s = (sd == 0) ? 32'h1 : sd;
        if (len == 0 || num == 0) return;
        nb = (len + TDB - 1) / TDB;
        for (int p = 0; p < num; p++) begin
            for (int i = 0; i < nb; i++) begin
                nbytes = (len - i*TDB < TDB) ? len - i*TDB : TDB;
                d = '0;
                k = '0;
                for (int j = 0; j < nbytes; j++) begin
                    k[j] = 1'b1;
                    d[j*8 +: 8] = pat ? s[(j%4)*8 +: 8] : 8'((i*TDB + j) % 256);
                end
                exp_dat.push_back(d);
                exp_keep.push_back(k);
                exp_last.push_back(i == nb - 1);
                s = lfsr_next(s);
            end
        end
    endtask

    task automatic run_stream(input string name, input int len, input int num, input int gap,
                              input bit pat, input logic [31:0] sd, input bit rnd, input bit poke);
        int total, idle;
        bit prev_stall, prev_final, after_tlast, finished, acc, r;
        logic [63:0] pd;
        logic [7:0]  pk;
        logic        pl;
        build_model(len, num, pat, sd);
        total = exp_dat.size();
        acc_dat.delete(); acc_keep.delete(); acc_last.delete();
        pkt_len_bytes = 16'(len); num_pkts = 8'(num); gap_cycles = 8'(gap);
        pattern_sel = pat; seed = sd; tready = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || m_axis_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL %s first_cycle: busy=%b tvalid=%b required 1 1", name, busy, m_axis_tvalid);
        end
        prev_stall = 0; prev_final = 0; after_tlast = 0; idle = 0; finished = 0;
        pd = '0; pk = '0; pl = 1'b0;
        for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
            if (prev_stall) begin
                checks++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== pd || m_axis_tkeep !== pk || m_axis_tlast !== pl) begin
                    errors++;
                    $display("FAIL %s stall_hold: v=%b d=%h k=%h l=%b required 1 %h %h %b",
                             name, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, pd, pk, pl);
                end
            end
            if (done === 1'b1) begin
                checks++;
                if (!prev_final || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s done_timing: after_final=%b busy=%b required 1 0", name, prev_final, busy);
                end
                finished = 1;
            end else if (prev_final) begin
                checks++; errors++;
                $display("FAIL %s done_missing: done=%b required 1", name, done);
                finished = 1;
            end else begin
                if (after_tlast) begin
                    if (m_axis_tvalid !== 1'b1) begin
                        idle++;
                    end else begin
                        checks++;
                        if (idle != gap) begin
                            errors++;
                            $display("FAIL %s gap_len: got %0d required %0d", name, idle, gap);
                        end
                        after_tlast = 0;
                    end
                end
                if (poke && cyc == 2) begin
                    start = 1'b1; pkt_len_bytes = 16'd3; num_pkts = 8'd1;
                    gap_cycles = 8'd0; pattern_sel = ~pat; seed = 32'h1234;
                end
                r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                tready = r;
                acc = (m_axis_tvalid === 1'b1) && r;
                prev_stall = (m_axis_tvalid === 1'b1) && !r;
                pd = m_axis_tdata; pk = m_axis_tkeep; pl = m_axis_tlast;
                prev_final = 0;
                if (acc) begin
                    checks++;
                    if (exp_dat.size() == 0) begin
                        errors++;
                        $display("FAIL %s extra_beat: d=%h required no beat", name, m_axis_tdata);
                    end else begin
                        if (m_axis_tdata !== exp_dat[0] || m_axis_tkeep !== exp_keep[0] || m_axis_tlast !== exp_last[0]) begin
                            errors++;
                            $display("FAIL %s beat: d=%h k=%h l=%b required %h %h %b", name,
                                     m_axis_tdata, m_axis_tkeep, m_axis_tlast, exp_dat[0], exp_keep[0], exp_last[0]);
                        end
                        void'(exp_dat.pop_front()); void'(exp_keep.pop_front()); void'(exp_last.pop_front());
                        prev_final = (exp_dat.size() == 0);
                    end
                    acc_dat.push_back(m_axis_tdata);
                    acc_keep.push_back(m_axis_tkeep);
                    acc_last.push_back(m_axis_tlast);
                    if (m_axis_tlast === 1'b1 && exp_dat.size() != 0) begin
                        after_tlast = 1;
                        idle = 0;
                    end
                end
                step();
                start = 1'b0;
            end
        end
        if (!finished) begin
            checks++; errors++;
            $display("FAIL %s timeout: %0d beats outstanding required 0", name, exp_dat.size());
        end
        checks++;
        if (beat_count !== 32'(total) || pkt_count !== 16'(num)) begin
            errors++;
            $display("FAIL %s counters: beats=%0d pkts=%0d required %0d %0d", name, beat_count, pkt_count, total, num);
        end
        tready = 1'b0;
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: done=%b busy=%b tvalid=%b required 0 0 0", name, done, busy, m_axis_tvalid);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            m_axis_tdata !== 64'h0 || m_axis_tkeep !== 8'h0 || beat_count !== 32'h0 || pkt_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: v=%b l=%b busy=%b done=%b d=%h k=%h bc=%0d pc=%0d required all 0",
                     m_axis_tvalid, m_axis_tlast, busy, done, m_axis_tdata, m_axis_tkeep, beat_count, pkt_count);
        end
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_len16();
        run_stream("len16", 16, 1, 0, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (acc_dat.size() != 2 || acc_dat[0] !== 64'h0706050403020100 || acc_dat[1] !== 64'h0F0E0D0C0B0A0908 ||
            acc_keep[0] !== 8'hFF || acc_keep[1] !== 8'hFF || acc_last[0] !== 1'b0 || acc_last[1] !== 1'b1) begin
            errors++;
            $display("FAIL len16_beats: n=%0d d0=%h d1=%h required 2 0706050403020100 0F0E0D0C0B0A0908",
                     acc_dat.size(), acc_dat.size() > 0 ? acc_dat[0] : 64'hx, acc_dat.size() > 1 ? acc_dat[1] : 64'hx);
        end
    endtask

    task automatic test_len11();
        run_stream("len11", 11, 1, 0, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (acc_dat.size() != 2 || acc_keep[1] !== 8'h07 || acc_dat[1] !== 64'h00000000000A0908) begin
            errors++;
            $display("FAIL len11_tail: n=%0d k=%h d=%h required 2 07 00000000000A0908", acc_dat.size(),
                     acc_keep.size() > 1 ? acc_keep[1] : 8'hx, acc_dat.size() > 1 ? acc_dat[1] : 64'hx);
        end
    endtask

    task automatic test_gap();
        run_stream("gap2", 8, 3, 2, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (pkt_count !== 16'd3 || beat_count !== 32'd3) begin
            errors++;
            $display("FAIL gap2_counts: pkts=%0d beats=%0d required 3 3", pkt_count, beat_count);
        end
        run_stream("gap0", 13, 3, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_stream("bp_counter", 37, 4, 1, 1'b0, 32'h0, 1'b1, 1'b1);
        run_stream("bp_lfsr", 29, 3, 0, 1'b1, $urandom, 1'b1, 1'b0);
        for (int t = 0; t < 3; t++) begin
            run_stream("bp_random", $urandom_range(1, 40), $urandom_range(1, 4), $urandom_range(0, 3),
                       1'($urandom_range(0, 1)), $urandom, 1'b1, 1'b0);
        end
    endtask

    task automatic test_lfsr();
        run_stream("lfsr_seed0", 16, 2, 0, 1'b1, 32'h0, 1'b0, 1'b0);
        checks++;
        if (acc_dat.size() < 2 || acc_dat[0] !== 64'h0000000100000001 || acc_dat[1] !== 64'h8020000380200003) begin
            errors++;
            $display("FAIL lfsr_first_steps: d0=%h d1=%h required 0000000100000001 8020000380200003",
                     acc_dat.size() > 0 ? acc_dat[0] : 64'hx, acc_dat.size() > 1 ? acc_dat[1] : 64'hx);
        end
    endtask

    task automatic test_len0();
        for (int t = 0; t < 2; t++) begin
            pkt_len_bytes = (t == 0) ? 16'd0 : 16'd24;
            num_pkts = (t == 0) ? 8'd3 : 8'd0;
            tready = 1'b1; start = 1'b1;
            step();
            start = 1'b0;
            checks++;
            if (m_axis_tvalid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL empty%0d_cycle1: v=%b busy=%b done=%b required 0 1 0", t, m_axis_tvalid, busy, done);
            end
            step();
            checks++;
            if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
                errors++;
                $display("FAIL empty%0d_cycle2: v=%b busy=%b done=%b required 0 0 1", t, m_axis_tvalid, busy, done);
            end
            step();
            checks++;
            if (done !== 1'b0 || beat_count !== 32'd0 || pkt_count !== 16'd0) begin
                errors++;
                $display("FAIL empty%0d_after: done=%b bc=%0d pc=%0d required 0 0 0", t, done, beat_count, pkt_count);
            end
        end
    endtask

    task automatic test_reset_mid();
        pkt_len_bytes = 16'd64; num_pkts = 8'd2; gap_cycles = 8'd0; pattern_sel = 1'b0;
        tready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        checks++;
        if (m_axis_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: tvalid=%b required 1", m_axis_tvalid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || busy !== 1'b0 || m_axis_tdata !== 64'h0 || beat_count !== 32'd0) begin
            errors++;
            $display("FAIL midreset_drop: v=%b l=%b busy=%b d=%h bc=%0d required 0 0 0 0 0",
                     m_axis_tvalid, m_axis_tlast, busy, m_axis_tdata, beat_count);
        end
        step(); step();
        rst_n = 1'b1;
        tready = 1'b0;
        step();
        run_stream("after_reset", 20, 2, 1, 1'b1, $urandom, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_len16();
        test_len11();
        test_gap();
        test_backpressure();
        test_lfsr();
        test_len0();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
